// File: rtl/heap_pq_pkg.sv
// Shared types and helpers for the heap_pq binary-heap priority queue.
// Holds the FSM state type, heap index arithmetic and the key ordering
// function. The ordering function takes the heap direction as an argument.
package heap_pq_pkg;

  // Controller states: idle, or walking one heap level per cycle.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SIFT_UP   = 2'd1,
    ST_SIFT_DOWN = 2'd2
  } state_e;

  // Keys are zero-extended to this width before comparison; DATA_W must not exceed it.
  localparam int unsigned CMP_W = 32'd256;

  // Parent of node i (only meaningful for i > 0).
  function automatic int unsigned parent_idx(input int unsigned i);
    return (i - 32'd1) >> 1;
  endfunction

  // Left child of node i.
  function automatic int unsigned left_idx(input int unsigned i);
    return (i << 1) + 32'd1;
  endfunction

  // Right child of node i.
  function automatic int unsigned right_idx(input int unsigned i);
    return (i << 1) + 32'd2;
  endfunction

  // True when key a must sit above key b; ties are never "better".
  function automatic logic key_better(input logic max_first,
                                      input logic [CMP_W-1:0] a,
                                      input logic [CMP_W-1:0] b);
    logic r;
    if (max_first) begin
      r = (a > b);
    end else begin
      r = (a < b);
    end
    return r;
  endfunction

endpackage

// File: rtl/heap_pq_cmp.sv
// Sift-down decision for one heap level: picks the better of the existing
// children and reports whether it must swap with the current node.
module heap_pq_cmp
  import heap_pq_pkg::*;
#(
  parameter int unsigned DATA_W    = 32'd32,
  parameter int unsigned MAX_FIRST = 32'd0
) (
  input  logic [DATA_W-1:0] node_i,
  input  logic [DATA_W-1:0] left_i,
  input  logic [DATA_W-1:0] right_i,
  input  logic              left_ok_i,
  input  logic              right_ok_i,
  output logic              sel_right_o,
  output logic              swap_o
);

  localparam logic MAXF = (MAX_FIRST != 32'd0);

  logic [DATA_W-1:0] child_s;

  // Choose the better child (left wins ties), then decide on the swap.
  always_comb begin
    sel_right_o = 1'b0;
    child_s     = left_i;
    swap_o      = 1'b0;
    if (right_ok_i && key_better(MAXF, CMP_W'(right_i), CMP_W'(left_i))) begin
      sel_right_o = 1'b1;
      child_s     = right_i;
    end else begin
      sel_right_o = 1'b0;
      child_s     = left_i;
    end
    if (left_ok_i) begin
      swap_o = key_better(MAXF, CMP_W'(child_s), CMP_W'(node_i));
    end else begin
      swap_o = 1'b0;
    end
  end

endmodule

// File: rtl/heap_pq.sv
// Binary-heap priority queue with valid/ready push and pop ports.
// Keys live in a register array; after each push or pop the controller
// restores heap order one level per cycle while the ports stall.
// Optional feature: define HEAP_PQ_HWM_EN to add the hwm (high-water mark) output.
module heap_pq
  import heap_pq_pkg::*;
#(
  parameter int unsigned DATA_W    = 32'd32,
  parameter int unsigned DEPTH     = 32'd15,
  parameter int unsigned MAX_FIRST = 32'd0
) (
  input  logic                         system1000,
  input  logic                         system1000_rst,
  input  logic                         flush,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [DATA_W-1:0]            push_data,
  output logic                         pop_valid,
  input  logic                         pop_ready,
  output logic [DATA_W-1:0]            pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
`ifdef HEAP_PQ_HWM_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   hwm
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 32'd1);
  // Index width covers child indices up to 2*DEPTH.
  localparam int unsigned IDX_W = CNT_W + 32'd1;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic        MAXF  = (MAX_FIRST != 32'd0);

  logic [DATA_W-1:0] heap_q [DEPTH];
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
`ifdef HEAP_PQ_HWM_EN
  logic [CNT_W-1:0]  hwm_q, hwm_d;
`endif

  logic              wr_a_en_s, wr_b_en_s;
  logic [IDX_W-1:0]  wr_a_idx_s, wr_b_idx_s;
  logic [DATA_W-1:0] wr_a_data_s, wr_b_data_s;

  logic              push_fire_s, pop_fire_s;
  logic [IDX_W-1:0]  cnt_ext_s, up_par_s, dn_left_s, dn_right_s, dn_child_s;
  logic [DATA_W-1:0] node_key_s, par_key_s, left_key_s, right_key_s, last_key_s;
  logic              up_swap_s, dn_swap_s, dn_sel_right_s, left_ok_s, right_ok_s;

  // Out-of-range reads return zero so no index ever leaves the array.
  function automatic logic [DATA_W-1:0] rd_key(input logic [IDX_W-1:0] i);
    logic [DATA_W-1:0] k;
    if (i < IDX_W'(DEPTH)) begin
      k = heap_q[AW'(i)];
    end else begin
      k = '0;
    end
    return k;
  endfunction

  assign push_ready  = (state_q == ST_IDLE) && (count_q != CNT_W'(DEPTH));
  assign pop_valid   = (state_q == ST_IDLE) && (count_q != '0);
  assign pop_data    = heap_q[0];
  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_W'(DEPTH));
`ifdef HEAP_PQ_HWM_EN
  assign hwm         = hwm_q;
`endif

  assign push_fire_s = push_valid && push_ready;
  assign pop_fire_s  = pop_valid && pop_ready;
  assign cnt_ext_s   = IDX_W'(count_q);

  assign up_par_s    = IDX_W'(parent_idx(32'(idx_q)));
  assign dn_left_s   = IDX_W'(left_idx(32'(idx_q)));
  assign dn_right_s  = IDX_W'(right_idx(32'(idx_q)));
  assign left_ok_s   = (dn_left_s < cnt_ext_s);
  assign right_ok_s  = (dn_right_s < cnt_ext_s);

  assign node_key_s  = rd_key(idx_q);
  assign par_key_s   = rd_key(up_par_s);
  assign left_key_s  = rd_key(dn_left_s);
  assign right_key_s = rd_key(dn_right_s);
  assign last_key_s  = rd_key(cnt_ext_s - IDX_W'(1));

  assign up_swap_s   = key_better(MAXF, CMP_W'(node_key_s), CMP_W'(par_key_s));
  assign dn_child_s  = dn_sel_right_s ? dn_right_s : dn_left_s;

  heap_pq_cmp #(
    .DATA_W   (DATA_W),
    .MAX_FIRST(MAX_FIRST)
  ) u_cmp (
    .node_i     (node_key_s),
    .left_i     (left_key_s),
    .right_i    (right_key_s),
    .left_ok_i  (left_ok_s),
    .right_ok_i (right_ok_s),
    .sel_right_o(dn_sel_right_s),
    .swap_o     (dn_swap_s)
  );

  // Next-state, count, sift index and up to two heap writes per cycle.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    wr_a_en_s   = 1'b0;
    wr_a_idx_s  = idx_q;
    wr_a_data_s = push_data;
    wr_b_en_s   = 1'b0;
    wr_b_idx_s  = idx_q;
    wr_b_data_s = push_data;
    if (flush) begin
      state_d = ST_IDLE;
      count_d = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (push_fire_s && pop_fire_s) begin
            // Replace: new key overwrites the root and sinks.
            wr_a_en_s   = 1'b1;
            wr_a_idx_s  = '0;
            wr_a_data_s = push_data;
            idx_d       = '0;
            state_d     = ST_SIFT_DOWN;
          end else if (push_fire_s) begin
            wr_a_en_s   = 1'b1;
            wr_a_idx_s  = cnt_ext_s;
            wr_a_data_s = push_data;
            count_d     = count_q + CNT_W'(1);
            idx_d       = cnt_ext_s;
            state_d     = ST_SIFT_UP;
          end else if (pop_fire_s) begin
            // Last leaf moves to the root; a single key needs no sift.
            wr_a_en_s   = 1'b1;
            wr_a_idx_s  = '0;
            wr_a_data_s = last_key_s;
            count_d     = count_q - CNT_W'(1);
            idx_d       = '0;
            state_d     = (count_q == CNT_W'(1)) ? ST_IDLE : ST_SIFT_DOWN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SIFT_UP: begin
          if (idx_q == '0) begin
            state_d = ST_IDLE;
          end else if (up_swap_s) begin
            wr_a_en_s   = 1'b1;
            wr_a_idx_s  = up_par_s;
            wr_a_data_s = node_key_s;
            wr_b_en_s   = 1'b1;
            wr_b_idx_s  = idx_q;
            wr_b_data_s = par_key_s;
            idx_d       = up_par_s;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SIFT_DOWN: begin
          if (dn_swap_s) begin
            wr_a_en_s   = 1'b1;
            wr_a_idx_s  = idx_q;
            wr_a_data_s = dn_sel_right_s ? right_key_s : left_key_s;
            wr_b_en_s   = 1'b1;
            wr_b_idx_s  = dn_child_s;
            wr_b_data_s = node_key_s;
            idx_d       = dn_child_s;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
`ifdef HEAP_PQ_HWM_EN
    if (flush) begin
      hwm_d = '0;
    end else if (count_d > hwm_q) begin
      hwm_d = count_d;
    end else begin
      hwm_d = hwm_q;
    end
`endif
  end

  // State registers with synchronous reset; heap storage is never reset.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      idx_q   <= '0;
`ifdef HEAP_PQ_HWM_EN
      hwm_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
`ifdef HEAP_PQ_HWM_EN
      hwm_q   <= hwm_d;
`endif
      if (wr_a_en_s) begin
        heap_q[AW'(wr_a_idx_s)] <= wr_a_data_s;
      end
      if (wr_b_en_s) begin
        heap_q[AW'(wr_b_idx_s)] <= wr_b_data_s;
      end
    end
  end

endmodule

// File: tb/tb_heap_pq.sv
// Self-checking bench for heap_pq: a min-heap and a max-heap instance share
// one stimulus stream; each has its own multiset reference model and an
// expected-pop queue drained by a per-instance monitor.
// Build with HEAP_PQ_HWM_EN defined to also exercise the hwm output.
module tb_heap_pq;

  localparam int DEPTH = 15;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk, rst, flush, push_valid, pop_ready;
  logic [31:0] push_data;
  logic push_ready_mn, pop_valid_mn, empty_mn, full_mn;
  logic push_ready_mx, pop_valid_mx, empty_mx, full_mx;
  logic [31:0] pop_data_mn, pop_data_mx;
  logic [CW-1:0] count_mn, count_mx;
`ifdef HEAP_PQ_HWM_EN
  logic [CW-1:0] hwm_mn, hwm_mx;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] model_mn[$];
  logic [31:0] model_mx[$];
  logic [31:0] exp_mn[$];
  logic [31:0] exp_mx[$];

  heap_pq #(.DATA_W(32), .DEPTH(DEPTH), .MAX_FIRST(0)) u_min (
    .system1000(clk), .system1000_rst(rst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready_mn), .push_data(push_data),
    .pop_valid(pop_valid_mn), .pop_ready(pop_ready), .pop_data(pop_data_mn),
    .count(count_mn), .empty(empty_mn), .full(full_mn)
`ifdef HEAP_PQ_HWM_EN
    , .hwm(hwm_mn)
`endif
  );

  heap_pq #(.DATA_W(32), .DEPTH(DEPTH), .MAX_FIRST(1)) u_max (
    .system1000(clk), .system1000_rst(rst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready_mx), .push_data(push_data),
    .pop_valid(pop_valid_mx), .pop_ready(pop_ready), .pop_data(pop_data_mx),
    .count(count_mx), .empty(empty_mx), .full(full_mx)
`ifdef HEAP_PQ_HWM_EN
    , .hwm(hwm_mx)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Index of the element that pops first from a multiset.
  function automatic int best_idx(input logic [31:0] q[$], input bit want_max);
    int b = 0;
    for (int i = 1; i < q.size(); i++) begin
      if (want_max ? (q[i] > q[b]) : (q[i] < q[b])) b = i;
    end
    return b;
  endfunction

  // Monitor: min instance pops against its expected queue, busy runs bounded.
  initial begin
    int busy = 0;
    forever begin
      @(negedge clk);
      if (!rst && !flush && pop_valid_mn && pop_ready) begin
        if (exp_mn.size() == 0) begin
          checks++; errors++;
          $display("FAIL mn_unexpected_pop: got %0d, expected no pop", pop_data_mn);
        end else begin
          check("mn_pop_data", pop_data_mn, exp_mn.pop_front());
        end
      end
      if (rst || flush) busy = 0;
      else if (!(push_ready_mn || pop_valid_mn)) busy++;
      else if (busy > 0) begin
        checks++;
        if (busy > 4) begin
          errors++;
          $display("FAIL mn_busy: got %0d cycles, expected at most 4", busy);
        end
        busy = 0;
      end
    end
  end

  // Monitor: max instance.
  initial begin
    int busy = 0;
    forever begin
      @(negedge clk);
      if (!rst && !flush && pop_valid_mx && pop_ready) begin
        if (exp_mx.size() == 0) begin
          checks++; errors++;
          $display("FAIL mx_unexpected_pop: got %0d, expected no pop", pop_data_mx);
        end else begin
          check("mx_pop_data", pop_data_mx, exp_mx.pop_front());
        end
      end
      if (rst || flush) busy = 0;
      else if (!(push_ready_mx || pop_valid_mx)) busy++;
      else if (busy > 0) begin
        checks++;
        if (busy > 4) begin
          errors++;
          $display("FAIL mx_busy: got %0d cycles, expected at most 4", busy);
        end
        busy = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!((push_ready_mn || pop_valid_mn) && (push_ready_mx || pop_valid_mx)) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL idle_timeout: still busy after %0d cycles", n);
    end
  endtask

  task automatic check_flags();
    int sz = model_mn.size();
    check("mn_push_ready", 32'(push_ready_mn), 32'(sz < DEPTH));
    check("mx_push_ready", 32'(push_ready_mx), 32'(sz < DEPTH));
    check("mn_pop_valid",  32'(pop_valid_mn),  32'(sz > 0));
    check("mx_pop_valid",  32'(pop_valid_mx),  32'(sz > 0));
    check("mn_full",  32'(full_mn),  32'(sz == DEPTH));
    check("mx_full",  32'(full_mx),  32'(sz == DEPTH));
    check("mn_empty", 32'(empty_mn), 32'(sz == 0));
    check("mx_empty", 32'(empty_mx), 32'(sz == 0));
  endtask

  task automatic do_op(input bit do_push, input logic [31:0] key, input bit do_pop);
    bit pf, qf;
    int bi;
    wait_idle();
    check("mn_push_ready", 32'(push_ready_mn), 32'(model_mn.size() < DEPTH));
    check("mn_pop_valid",  32'(pop_valid_mn),  32'(model_mn.size() > 0));
    pf = do_push && (model_mn.size() < DEPTH);
    qf = do_pop && (model_mn.size() > 0);
    push_valid = do_push;
    push_data  = key;
    pop_ready  = do_pop;
    if (qf) begin
      bi = best_idx(model_mn, 1'b0);
      exp_mn.push_back(model_mn[bi]);
      model_mn.delete(bi);
      bi = best_idx(model_mx, 1'b1);
      exp_mx.push_back(model_mx[bi]);
      model_mx.delete(bi);
    end
    if (pf) begin
      model_mn.push_back(key);
      model_mx.push_back(key);
    end
    @(posedge clk); #1;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    check("mn_count", 32'(count_mn), 32'(model_mn.size()));
    check("mx_count", 32'(count_mx), 32'(model_mx.size()));
  endtask

  task automatic do_flush(input bit with_push, input logic [31:0] key);
    wait_idle();
    flush      = 1'b1;
    push_valid = with_push;
    push_data  = key;
    pop_ready  = 1'b0;
    @(posedge clk); #1;
    flush      = 1'b0;
    push_valid = 1'b0;
    model_mn.delete();
    model_mx.delete();
    check("flush_mn_count", 32'(count_mn), 32'd0);
    check("flush_mx_count", 32'(count_mx), 32'd0);
    check("flush_mn_pop_valid", 32'(pop_valid_mn), 32'd0);
    check("flush_mx_pop_valid", 32'(pop_valid_mx), 32'd0);
`ifdef HEAP_PQ_HWM_EN
    check("flush_mn_hwm", 32'(hwm_mn), 32'd0);
    check("flush_mx_hwm", 32'(hwm_mx), 32'd0);
`endif
  endtask

  task automatic drain();
    int n = 0;
    while (model_mn.size() > 0 && n < 100) begin
      do_op(1'b0, 32'd0, 1'b1);
      n++;
    end
    wait_idle();
    check_flags();
  endtask

  initial begin
    logic [31:0] seq1 [5];
    logic [31:0] r;
    rst = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; push_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state while reset is held.
    check_flags();
    check("rst_mn_count", 32'(count_mn), 32'd0);
`ifdef HEAP_PQ_HWM_EN
    check("rst_mn_hwm", 32'(hwm_mn), 32'd0);
`endif
    rst = 1'b0;

    // Five distinct keys, then drain in priority order.
    seq1 = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd5};
    foreach (seq1[i]) do_op(1'b1, seq1[i], 1'b0);
    drain();

    // Fill to capacity with random keys; push while full must be dropped.
    for (int i = 0; i < DEPTH; i++) do_op(1'b1, $urandom, 1'b0);
    wait_idle();
    check_flags();
    do_op(1'b1, 32'd12345, 1'b1);
    drain();

    // Replace on {2,4,6}.
    do_op(1'b1, 32'd2, 1'b0);
    do_op(1'b1, 32'd4, 1'b0);
    do_op(1'b1, 32'd6, 1'b0);
    do_op(1'b1, 32'd5, 1'b1);
    drain();

    // Duplicate keys.
    do_op(1'b1, 32'd4, 1'b0);
    do_op(1'b1, 32'd4, 1'b0);
    do_op(1'b1, 32'd4, 1'b0);
    do_op(1'b1, 32'd1, 1'b0);
    drain();

    // Reset while both instances are sifting down.
    for (int i = 0; i < 5; i++) do_op(1'b1, $urandom_range(0, 100), 1'b0);
    do_op(1'b0, 32'd0, 1'b1);
    check("sift_mn_busy", 32'(pop_valid_mn || push_ready_mn), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    model_mn.delete();
    model_mx.delete();
    check_flags();
    check("rst2_mn_count", 32'(count_mn), 32'd0);
    rst = 1'b0;

    // Flush with a simultaneous push: the push is dropped.
    for (int i = 0; i < 3; i++) do_op(1'b1, $urandom, 1'b0);
    do_flush(1'b1, 32'd77);
    do_op(1'b1, 32'd500, 1'b0);
    drain();

`ifdef HEAP_PQ_HWM_EN
    for (int i = 0; i < 6; i++) do_op(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 4; i++) do_op(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 2; i++) do_op(1'b1, $urandom, 1'b0);
    wait_idle();
    check("hwm_mn", 32'(hwm_mn), 32'd6);
    check("hwm_mx", 32'(hwm_mx), 32'd6);
    do_flush(1'b0, 32'd0);
`endif

    // Random mix of push, pop, replace and occasional flush.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 0) push_data = $urandom;
      else push_data = $urandom_range(0, 7);
      if ($urandom_range(0, 59) == 0) do_flush(1'b1, push_data);
      else if (r < 4) do_op(1'b1, push_data, 1'b0);
      else if (r < 7) do_op(1'b0, 32'd0, 1'b1);
      else do_op(1'b1, push_data, 1'b1);
    end
    drain();

    repeat (3) @(posedge clk);
    #1;
    check("mn_exp_left", 32'(exp_mn.size()), 32'd0);
    check("mx_exp_left", 32'(exp_mx.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
